// File: rtl/synth_pkg.sv
// Definitions shared by the voice allocator, envelope and oscillator blocks:
// default widths, allocator FSM encoding and velocity word field layout.
package synth_pkg;

  localparam int NOTE_BITS_DEF  = 7;
  localparam int VEL_BITS_DEF   = 32;

  // The velocity word carries two envelope targets side by side.
  localparam int ENV_FIELD_BITS = 16;
  localparam int VEL_ATTACK_LSB = 16;
  localparam int VEL_DECAY_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/voice_slot.sv
// State of one synth voice: occupancy, gate, held note, velocity and a
// saturating age used for voice stealing.
module voice_slot
  import synth_pkg::*;
#(
  parameter int NOTE_BITS = NOTE_BITS_DEF,
  parameter int VEL_BITS  = VEL_BITS_DEF,
  parameter int AGE_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 rel,
  input  logic                 age_inc,
  input  logic                 available,
  input  logic [NOTE_BITS-1:0] load_note,
  input  logic [VEL_BITS-1:0]  load_velocity,
  output logic                 busy,
  output logic                 en,
  output logic [NOTE_BITS-1:0] note,
  output logic [VEL_BITS-1:0]  velocity,
  output logic [AGE_BITS-1:0]  age
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      en       <= 1'b0;
      note     <= '0;
      velocity <= '0;
      age      <= '0;
    end else if (load) begin
      busy     <= 1'b1;
      en       <= 1'b1;
      note     <= load_note;
      velocity <= load_velocity;
      age      <= '0;
    end else begin
      if (rel) en <= 1'b0;
      // A commit touching this voice outranks the envelope's idle pulse.
      if (available && !rel) busy <= 1'b0;
      if (age_inc && busy && (age != '1)) age <= age + AGE_BITS'(1);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans all voices once per event, then assigns
// a note-on to a matching, free or oldest voice, or releases a note-off.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_BITS  = NOTE_BITS_DEF,
  parameter int VEL_BITS   = VEL_BITS_DEF,
  parameter int AGE_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_note_on,
  input  logic [NOTE_BITS-1:0]           ev_note,
  input  logic [VEL_BITS-1:0]            ev_velocity,
  input  logic [NUM_VOICES-1:0]          voice_available,
  output logic [NUM_VOICES-1:0]          voice_en,
  output logic [NUM_VOICES*VEL_BITS-1:0] voice_velocity,
  output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
  output logic [NUM_VOICES-1:0]          voice_busy,
  output logic                           steal
);

  localparam int IDX_BITS = $clog2(NUM_VOICES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VOICES - 1);

  alloc_state_e state, state_nxt;
  logic                 armed;
  logic                 accept;
  logic [IDX_BITS-1:0]  idx;

  logic                 ev_on_q;
  logic [NOTE_BITS-1:0] ev_note_q;
  logic [VEL_BITS-1:0]  ev_vel_q;

  logic                 match_found, free_found, old_found;
  logic [IDX_BITS-1:0]  match_idx, free_idx, old_idx;
  logic [AGE_BITS-1:0]  old_age;

  logic                 do_load, do_release, steal_nxt;
  logic [IDX_BITS-1:0]  tgt_idx;

  logic [NUM_VOICES-1:0] slot_busy, slot_en, slot_load, slot_rel, slot_age_inc;
  logic [NOTE_BITS-1:0]  slot_note [NUM_VOICES];
  logic [AGE_BITS-1:0]   slot_age  [NUM_VOICES];

  // Holds ev_ready low while in reset and releases it on the first clock
  // edge after reset falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else     armed <= 1'b1;
  end

  assign ev_ready = armed && (state == S_IDLE);
  assign accept   = ev_valid && ev_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SCAN;
      S_SCAN:   if (idx == LAST_IDX) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Event capture and the per-voice scan of candidates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      ev_vel_q    <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        ev_on_q     <= ev_note_on;
        ev_note_q   <= ev_note;
        ev_vel_q    <= ev_velocity;
        idx         <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
        old_found   <= 1'b0;
        old_age     <= '0;
      end
    end else if (state == S_SCAN) begin
      if (!match_found && slot_en[idx] && (slot_note[idx] == ev_note_q)) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!free_found && !slot_busy[idx]) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      // Strictly greater keeps the lowest index on equal ages.
      if (slot_busy[idx] && (!old_found || (slot_age[idx] > old_age))) begin
        old_found <= 1'b1;
        old_idx   <= idx;
        old_age   <= slot_age[idx];
      end
      idx <= idx + IDX_BITS'(1);
    end
  end

  always_comb begin
    do_load    = 1'b0;
    do_release = 1'b0;
    steal_nxt  = 1'b0;
    tgt_idx    = '0;
    if (state == S_COMMIT) begin
      if (ev_on_q) begin
        if (match_found) begin
          do_load = 1'b1;
          tgt_idx = match_idx;
        end else if (free_found) begin
          do_load = 1'b1;
          tgt_idx = free_idx;
        end else if (old_found) begin
          do_load   = 1'b1;
          tgt_idx   = old_idx;
          steal_nxt = 1'b1;
        end
      end else if (match_found) begin
        do_release = 1'b1;
        tgt_idx    = match_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) steal <= 1'b0;
    else     steal <= steal_nxt;
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    assign slot_load[i]    = do_load    && (tgt_idx == IDX_BITS'(i));
    assign slot_rel[i]     = do_release && (tgt_idx == IDX_BITS'(i));
    assign slot_age_inc[i] = do_load    && (tgt_idx != IDX_BITS'(i));

    voice_slot #(
      .NOTE_BITS (NOTE_BITS),
      .VEL_BITS  (VEL_BITS),
      .AGE_BITS  (AGE_BITS)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .load          (slot_load[i]),
      .rel           (slot_rel[i]),
      .age_inc       (slot_age_inc[i]),
      .available     (voice_available[i]),
      .load_note     (ev_note_q),
      .load_velocity (ev_vel_q),
      .busy          (slot_busy[i]),
      .en            (slot_en[i]),
      .note          (slot_note[i]),
      .velocity      (voice_velocity[i*VEL_BITS +: VEL_BITS]),
      .age           (slot_age[i])
    );

    assign voice_note[i*NOTE_BITS +: NOTE_BITS] = slot_note[i];
  end

  assign voice_busy = slot_busy;
  assign voice_en   = slot_en;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios followed by
// randomized events against an array-based allocation model.
module tb_voice_allocator;
  import synth_pkg::*;

  localparam int N  = 8;
  localparam int NB = 7;
  localparam int VB = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_note_on = 1'b0;
  logic [NB-1:0]   ev_note = '0;
  logic [VB-1:0]   ev_velocity = '0;
  logic [N-1:0]    voice_available = '0;
  logic [N-1:0]    voice_en;
  logic [N*VB-1:0] voice_velocity;
  logic [N*NB-1:0] voice_note;
  logic [N-1:0]    voice_busy;
  logic            steal;

  voice_allocator #(.NUM_VOICES(N), .NOTE_BITS(NB), .VEL_BITS(VB), .AGE_BITS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .ev_valid        (ev_valid),
    .ev_ready        (ev_ready),
    .ev_note_on      (ev_note_on),
    .ev_note         (ev_note),
    .ev_velocity     (ev_velocity),
    .voice_available (voice_available),
    .voice_en        (voice_en),
    .voice_velocity  (voice_velocity),
    .voice_note      (voice_note),
    .voice_busy      (voice_busy),
    .steal           (steal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of every voice.
  logic [N-1:0]  m_busy, m_en;
  logic [NB-1:0] m_note [N];
  logic [VB-1:0] m_vel  [N];
  int            m_age  [N];
  logic          m_steal;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*NB-1:0] exp_notes();
    logic [N*NB-1:0] v;
    for (int i = 0; i < N; i++) v[i*NB +: NB] = m_note[i];
    return v;
  endfunction

  function automatic logic [N*VB-1:0] exp_vels();
    logic [N*VB-1:0] v;
    for (int i = 0; i < N; i++) v[i*VB +: VB] = m_vel[i];
    return v;
  endfunction

  task automatic model_reset();
    m_busy  = '0;
    m_en    = '0;
    m_steal = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_note[i] = '0;
      m_vel[i]  = '0;
      m_age[i]  = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_en"},    256'(voice_en),       256'(m_en));
    check({tag, "_busy"},  256'(voice_busy),     256'(m_busy));
    check({tag, "_note"},  256'(voice_note),     256'(exp_notes()));
    check({tag, "_vel"},   256'(voice_velocity), 256'(exp_vels()));
    check({tag, "_steal"}, 256'(steal),          256'(m_steal));
  endtask

  function automatic logic [N-1:0] rand_release_pulses();
    return m_busy & ~m_en & N'($urandom) & N'($urandom);
  endfunction

  // One idle cycle carrying the given envelope-idle pulses.
  task automatic idle_step(input logic [N-1:0] p);
    voice_available = p;
    tick();
    voice_available = '0;
    m_busy  = m_busy & ~p;
    m_steal = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ev_valid = 1'b0;
    voice_available = '0;
    #1;
    model_reset();
    check_all("rst");
    check("rst_ready", 256'(ev_ready), 256'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rel_ready", 256'(ev_ready), 256'(1'b0));
    tick();
    check("rst_first_edge_ready", 256'(ev_ready), 256'(1'b1));
  endtask

  // Full event: handshake, NUM_VOICES scan cycles, commit, one idle cycle.
  task automatic run_event(input logic on, input logic [NB-1:0] note, input logic [VB-1:0] vel,
                           input logic [N-1:0] commit_pulse, input bit rand_pulses);
    int            w;
    logic [N-1:0]  seen_busy, p, busy_before, pre_en;
    int            match, free, oldest, tgt;
    w = 0;
    while (ev_ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("ready_wait", 256'(ev_ready), 256'(1'b1));
    ev_valid    = 1'b1;
    ev_note_on  = on;
    ev_note     = note;
    ev_velocity = vel;
    tick();
    ev_valid    = 1'b0;
    ev_note_on  = 1'($urandom);
    ev_note     = NB'($urandom);
    ev_velocity = $urandom;
    check("scan_ready_low", 256'(ev_ready), 256'(1'b0));
    pre_en = m_en;
    for (int c = 0; c < N; c++) begin
      seen_busy[c] = m_busy[c];
      p = rand_pulses ? rand_release_pulses() : '0;
      voice_available = p;
      tick();
      m_busy = m_busy & ~p;
    end
    voice_available = '0;
    check("pre_commit_en", 256'(voice_en), 256'(pre_en));

    match = -1; free = -1; oldest = -1;
    for (int k = 0; k < N; k++) begin
      if (match < 0 && m_en[k] && m_note[k] == note) match = k;
      if (free < 0 && !seen_busy[k]) free = k;
      if (seen_busy[k] && (oldest < 0 || m_age[k] > m_age[oldest])) oldest = k;
    end
    tgt = -1;
    m_steal = 1'b0;
    if (on) begin
      if (match >= 0)     tgt = match;
      else if (free >= 0) tgt = free;
      else begin
        tgt = oldest;
        m_steal = 1'b1;
      end
    end else if (match >= 0) begin
      tgt = match;
    end

    p = commit_pulse | (rand_pulses ? rand_release_pulses() : '0);
    busy_before = m_busy;
    for (int k = 0; k < N; k++) begin
      if (on && k == tgt) begin
        m_busy[k] = 1'b1;
        m_en[k]   = 1'b1;
        m_note[k] = note;
        m_vel[k]  = vel;
        m_age[k]  = 0;
      end else begin
        if (on && busy_before[k] && m_age[k] < 255) m_age[k]++;
        if (!on && k == tgt) m_en[k] = 1'b0;
        else if (p[k]) m_busy[k] = 1'b0;
      end
    end
    voice_available = p;
    tick();
    voice_available = '0;
    check_all("commit");
    check("post_commit_ready", 256'(ev_ready), 256'(1'b1));
    idle_step(rand_pulses ? rand_release_pulses() : '0);
    check_all("after_commit");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Single note-on lands on voice 0.
    do_reset();
    run_event(1'b1, 7'd60, 32'hF000_2000, '0, 1'b0);
    check("t1_en",     256'(voice_en),   256'(8'h01));
    check("t1_busy",   256'(voice_busy), 256'(8'h01));
    check("t1_vel0",   256'(voice_velocity[VB-1:0]), 256'(32'hF000_2000));
    check("t1_attack", 256'(voice_velocity[VEL_ATTACK_LSB +: ENV_FIELD_BITS]), 256'(16'hF000));
    check("t1_decay",  256'(voice_velocity[VEL_DECAY_LSB +: ENV_FIELD_BITS]),  256'(16'h2000));

    // Three notes, release of the middle one, then its envelope goes idle.
    run_event(1'b1, 7'd62, 32'h1111_2222, '0, 1'b0);
    run_event(1'b1, 7'd64, 32'h3333_4444, '0, 1'b0);
    check("t2_en3", 256'(voice_en), 256'(8'h07));
    run_event(1'b0, 7'd62, 32'h0, '0, 1'b0);
    check("t2_off_en",   256'(voice_en),   256'(8'h05));
    check("t2_off_busy", 256'(voice_busy), 256'(8'h07));
    idle_step(8'h02);
    check("t2_avail_busy", 256'(voice_busy), 256'(8'h05));
    check_all("t2_avail");

    // Fill every voice, then steal the oldest.
    do_reset();
    for (int n = 60; n < 68; n++) run_event(1'b1, NB'(n), 32'(n) << 8, '0, 1'b0);
    check("t3_full", 256'(voice_en), 256'(8'hFF));
    run_event(1'b1, 7'd70, 32'hABCD_0123, '0, 1'b0);
    check("t3_note0", 256'(voice_note[NB-1:0]), 256'(7'd70));
    check("t3_en",    256'(voice_en), 256'(8'hFF));

    // Retrigger of a held note reuses its voice.
    do_reset();
    run_event(1'b1, 7'd60, 32'h1000_0100, '0, 1'b0);
    run_event(1'b1, 7'd60, 32'h2000_0200, '0, 1'b0);
    check("t4_en",   256'(voice_en), 256'(8'h01));
    check("t4_vel0", 256'(voice_velocity[VB-1:0]), 256'(32'h2000_0200));

    // Note-off for a note nobody holds.
    run_event(1'b0, 7'd50, 32'h0, '0, 1'b0);
    check("t5_en", 256'(voice_en), 256'(8'h01));

    // Idle pulse on the voice being allocated loses to the commit.
    do_reset();
    for (int n = 0; n < 3; n++) run_event(1'b1, NB'(40 + n), 32'h5555_0000, '0, 1'b0);
    run_event(1'b1, 7'd80, 32'h7777_8888, 8'h08, 1'b0);
    check("t6_busy3", 256'(voice_busy[3]), 256'(1'b1));

    // Reset in the middle of a scan aborts everything.
    w_reset_mid: begin
      ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd90; ev_velocity = 32'h9999_9999;
      tick();
      ev_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      model_reset();
      check_all("t7_async");
      check("t7_ready", 256'(ev_ready), 256'(1'b0));
      tick();
      check_all("t7_edge");
      rst = 1'b0;
      tick();
      check("t7_ready_back", 256'(ev_ready), 256'(1'b1));
    end

    // Randomized traffic with envelope-idle pulses during scans and commits.
    do_reset();
    for (int e = 0; e < 150; e++) begin
      run_event($urandom_range(0, 9) < 6, NB'(60 + $urandom_range(0, 11)), $urandom, '0, 1'b1);
      repeat ($urandom_range(0, 2)) idle_step(rand_release_pulses());
    end
    check_all("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
